// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared widths and FSM state type for the AES output serializer
package aes_pkg;

  localparam int AES_BLOCK_W   = 128;
  localparam int CT_WORD_W     = 32;
  localparam int WORDS_PER_BLK = 4;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/aes_blk_fifo.sv
// rtl/aes_blk_fifo.sv - DEPTH x 128-bit block buffer with push/pop, full/empty and occupancy count
module aes_blk_fifo
  import aes_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [AES_BLOCK_W-1:0] i_data,
  output logic [AES_BLOCK_W-1:0] o_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [CNT_W-1:0]       o_count
);

  logic [AES_BLOCK_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [CNT_W-1:0]       r_count;

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
      if (i_pop)  r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
      if (i_push && !i_pop)      r_count <= r_count + CNT_W'(1);
      else if (i_pop && !i_push) r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/aes_out_serializer.sv
// rtl/aes_out_serializer.sv - buffers 128-bit AES ciphertext blocks and streams them as four 32-bit words
module aes_out_serializer
  import aes_pkg::*;
#(
  parameter  int DEPTH     = 2,
  parameter  bit MSB_FIRST = 1'b1,
  localparam int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   valid_out,
  input  logic [AES_BLOCK_W-1:0] cipher_text_128,
  input  logic                   ct_word_ready,
  input  logic                   clear_overflow,
  output logic                   ct_word_valid,
  output logic [CT_WORD_W-1:0]   ct_word,
  output logic                   ct_word_last,
  output logic [CNT_W-1:0]       blk_count,
  output logic                   overflow
);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [1:0]             r_idx;
  logic                   r_overflow;
  logic                   w_xfer;
  logic                   w_pop;
  logic                   w_push;
  logic                   w_drop;
  logic                   w_full;
  logic                   w_empty;
  logic [AES_BLOCK_W-1:0] w_head;
  logic [1:0]             w_sel;
  logic [CT_WORD_W-1:0]   w_word;

  // A full buffer still accepts a block when its head pops on the same edge.
  assign w_xfer = (r_state == SEND) && ct_word_ready;
  assign w_pop  = w_xfer && (r_idx == 2'd3) && !w_empty;
  assign w_push = valid_out && (!w_full || w_pop);
  assign w_drop = valid_out && w_full && !w_pop;

  aes_blk_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (cipher_text_128),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (blk_count)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_push) w_state_nxt = SEND;
      SEND: if (w_pop && (blk_count == CNT_W'(1)) && !w_push) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_idx      <= 2'd0;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_xfer) r_idx <= r_idx + 2'd1;
      if (w_drop)              r_overflow <= 1'b1;
      else if (clear_overflow) r_overflow <= 1'b0;
    end
  end

  // w_sel is the 32-bit lane number counted from bit 0 of the head block.
  always_comb begin
    w_sel  = MSB_FIRST ? (2'd3 - r_idx) : r_idx;
    w_word = '0;
    case (w_sel)
      2'd0: w_word = w_head[CT_WORD_W-1:0];
      2'd1: w_word = w_head[2*CT_WORD_W-1:CT_WORD_W];
      2'd2: w_word = w_head[3*CT_WORD_W-1:2*CT_WORD_W];
      2'd3: w_word = w_head[4*CT_WORD_W-1:3*CT_WORD_W];
      default: w_word = '0;
    endcase
  end

  assign ct_word_valid = (r_state == SEND);
  assign ct_word       = ct_word_valid ? w_word : '0;
  assign ct_word_last  = ct_word_valid && (r_idx == 2'd3);
  assign overflow      = r_overflow;

endmodule

// File: tb/tb_aes_out_serializer.sv
// tb/tb_aes_out_serializer.sv - directed self-checking bench for aes_out_serializer
module tb_aes_out_serializer;

  logic         clk;
  logic         reset;
  logic         valid_out;
  logic [127:0] cipher_text_128;
  logic         ct_word_ready;
  logic         clear_overflow;
  logic         ct_word_valid;
  logic [31:0]  ct_word;
  logic         ct_word_last;
  logic [1:0]   blk_count;
  logic         overflow;

  int tests;
  int fails;

  localparam logic [127:0] BLK_A = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] BLK_B = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] BLK_C = 128'hdeadbeefcafef00d0123456789abcdef;
  localparam logic [127:0] BLK_D = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;

  aes_out_serializer #(
    .DEPTH     (2),
    .MSB_FIRST (1'b1)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .valid_out       (valid_out),
    .cipher_text_128 (cipher_text_128),
    .ct_word_ready   (ct_word_ready),
    .clear_overflow  (clear_overflow),
    .ct_word_valid   (ct_word_valid),
    .ct_word         (ct_word),
    .ct_word_last    (ct_word_last),
    .blk_count       (blk_count),
    .overflow        (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // MSB-first word i of a block: bits [127-32i -: 32].
  function automatic logic [31:0] wd(input logic [127:0] b, input int i);
    logic [127:0] t;
    t = b >> (32 * (3 - i));
    return t[31:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; valid_out = 1'b0; cipher_text_128 = '0;
    ct_word_ready = 1'b0; clear_overflow = 1'b0;
    #3;
    tests++; if (ct_word_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", ct_word_valid); end
    tests++; if (ct_word !== 32'h0) begin fails++; $display("FAIL reset_word got %h want 0", ct_word); end
    tests++; if (blk_count !== 2'd0) begin fails++; $display("FAIL reset_count got %0d want 0", blk_count); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_ovf got %b want 0", overflow); end
    step(); step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_single();
    valid_out = 1'b1; cipher_text_128 = BLK_A; ct_word_ready = 1'b1;
    step();
    valid_out = 1'b0; cipher_text_128 = '0;
    for (int i = 0; i < 4; i++) begin
      tests++; if (ct_word_valid !== 1'b1) begin fails++; $display("FAIL single_valid[%0d] got %b want 1", i, ct_word_valid); end
      tests++; if (ct_word !== wd(BLK_A, i)) begin fails++; $display("FAIL single_word[%0d] got %h want %h", i, ct_word, wd(BLK_A, i)); end
      tests++; if (ct_word_last !== (i == 3)) begin fails++; $display("FAIL single_last[%0d] got %b want %b", i, ct_word_last, (i == 3)); end
      step();
    end
    tests++; if (ct_word_valid !== 1'b0 || ct_word !== 32'h0) begin fails++; $display("FAIL single_end got v=%b w=%h want v=0 w=0", ct_word_valid, ct_word); end
  endtask

  task automatic test_backpressure();
    valid_out = 1'b1; cipher_text_128 = BLK_A; ct_word_ready = 1'b1;
    step();
    valid_out = 1'b0;
    tests++; if (ct_word !== wd(BLK_A, 0)) begin fails++; $display("FAIL bp_word0 got %h want %h", ct_word, wd(BLK_A, 0)); end
    step();
    ct_word_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      tests++; if (ct_word !== 32'h6a7b0430 || ct_word_valid !== 1'b1) begin fails++; $display("FAIL bp_hold[%0d] got v=%b w=%h want v=1 w=6a7b0430", c, ct_word_valid, ct_word); end
    end
    ct_word_ready = 1'b1;
    for (int i = 2; i < 4; i++) begin
      step();
      tests++; if (ct_word !== wd(BLK_A, i)) begin fails++; $display("FAIL bp_word[%0d] got %h want %h", i, ct_word, wd(BLK_A, i)); end
    end
    tests++; if (ct_word_last !== 1'b1) begin fails++; $display("FAIL bp_last got %b want 1", ct_word_last); end
    step();
    tests++; if (ct_word_valid !== 1'b0) begin fails++; $display("FAIL bp_end got %b want 0", ct_word_valid); end
  endtask

  task automatic test_back_to_back();
    int exp_cnt [9] = '{1, 2, 2, 2, 1, 1, 1, 1, 0};
    valid_out = 1'b1; cipher_text_128 = BLK_A; ct_word_ready = 1'b1;
    step();
    for (int c = 0; c < 9; c++) begin
      tests++; if (blk_count !== 2'(exp_cnt[c])) begin fails++; $display("FAIL b2b_count[%0d] got %0d want %0d", c, blk_count, exp_cnt[c]); end
      if (c < 8) begin
        tests++; if (ct_word_valid !== 1'b1 || ct_word !== wd((c < 4) ? BLK_A : BLK_B, c % 4)) begin
          fails++; $display("FAIL b2b_word[%0d] got v=%b w=%h want v=1 w=%h", c, ct_word_valid, ct_word, wd((c < 4) ? BLK_A : BLK_B, c % 4));
        end
      end
      if (c == 0) cipher_text_128 = BLK_B;
      else valid_out = 1'b0;
      step();
    end
  endtask

  task automatic test_overflow();
    ct_word_ready = 1'b0; valid_out = 1'b1;
    cipher_text_128 = BLK_A; step();
    cipher_text_128 = BLK_B; step();
    cipher_text_128 = BLK_C; step();
    valid_out = 1'b0;
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_set got %b want 1", overflow); end
    tests++; if (blk_count !== 2'd2) begin fails++; $display("FAIL ovf_count got %0d want 2", blk_count); end
    tests++; if (ct_word !== wd(BLK_A, 0)) begin fails++; $display("FAIL ovf_head got %h want %h", ct_word, wd(BLK_A, 0)); end
    clear_overflow = 1'b1; step(); clear_overflow = 1'b0;
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL ovf_clear got %b want 0", overflow); end
    clear_overflow = 1'b1; valid_out = 1'b1; cipher_text_128 = BLK_C; step();
    clear_overflow = 1'b0; valid_out = 1'b0;
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_prio got %b want 1", overflow); end
    clear_overflow = 1'b1; step(); clear_overflow = 1'b0;
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL ovf_clear2 got %b want 0", overflow); end
  endtask

  task automatic test_full_pop();
    ct_word_ready = 1'b1;
    step(); step(); step();
    tests++; if (ct_word_last !== 1'b1 || ct_word !== wd(BLK_A, 3)) begin fails++; $display("FAIL fp_pre got l=%b w=%h want l=1 w=%h", ct_word_last, ct_word, wd(BLK_A, 3)); end
    valid_out = 1'b1; cipher_text_128 = BLK_D;
    step();
    valid_out = 1'b0;
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL fp_ovf got %b want 0", overflow); end
    tests++; if (blk_count !== 2'd2) begin fails++; $display("FAIL fp_count got %0d want 2", blk_count); end
    for (int j = 0; j < 8; j++) begin
      tests++; if (ct_word_valid !== 1'b1 || ct_word !== wd((j < 4) ? BLK_B : BLK_D, j % 4)) begin
        fails++; $display("FAIL fp_drain[%0d] got v=%b w=%h want v=1 w=%h", j, ct_word_valid, ct_word, wd((j < 4) ? BLK_B : BLK_D, j % 4));
      end
      step();
    end
    tests++; if (ct_word_valid !== 1'b0 || blk_count !== 2'd0) begin fails++; $display("FAIL fp_end got v=%b n=%0d want v=0 n=0", ct_word_valid, blk_count); end
  endtask

  task automatic test_reset_mid();
    valid_out = 1'b1; cipher_text_128 = BLK_A; ct_word_ready = 1'b1;
    step();
    valid_out = 1'b0;
    step();
    tests++; if (ct_word !== wd(BLK_A, 1)) begin fails++; $display("FAIL rm_word1 got %h want %h", ct_word, wd(BLK_A, 1)); end
    #2 reset = 1'b0;
    #1;
    tests++; if (ct_word_valid !== 1'b0 || ct_word !== 32'h0 || ct_word_last !== 1'b0) begin
      fails++; $display("FAIL rm_async got v=%b w=%h l=%b want 0/0/0", ct_word_valid, ct_word, ct_word_last);
    end
    tests++; if (blk_count !== 2'd0) begin fails++; $display("FAIL rm_count got %0d want 0", blk_count); end
    step();
    reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      tests++; if (ct_word_valid !== 1'b0) begin fails++; $display("FAIL rm_quiet[%0d] got %b want 0", c, ct_word_valid); end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/aes_out_serializer.md
AES_OUT_SERIALIZER -- requirements
Module: aes_out_serializer

Interface
REQ-001 Parameter DEPTH, default 2, number of 128-bit ciphertext blocks buffered (legal values 1..4).
REQ-002 Parameter MSB_FIRST, default 1; 1 sends bits [127:96] first, 0 sends bits [31:0] first.
REQ-003 clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 valid_out  input  1  AES core output strobe; cipher_text_128 is valid in this cycle.
REQ-006 cipher_text_128  input  128  ciphertext block from the AES core.
REQ-007 ct_word_ready  input  1  downstream consumer can accept a word.
REQ-008 clear_overflow  input  1  single-cycle pulse that clears the overflow flag.
REQ-009 ct_word_valid  output  1  ct_word holds a valid word.
REQ-010 ct_word  output  32  current ciphertext word.
REQ-011 ct_word_last  output  1  high with the 4th (final) word of a block.
REQ-012 blk_count  output  $clog2(DEPTH+1)  number of blocks held, including any partially sent block.
REQ-013 overflow  output  1  sticky flag: a block was dropped.

Function
REQ-014 The block shall capture cipher_text_128 into the tail of the block buffer on any rising edge where valid_out=1 and the buffer is not full.
REQ-015 When valid_out=1 and the buffer is full with no pop in the same cycle, the block shall discard the input block and set overflow at that edge.
REQ-016 When the buffer is full and the final word transfers in the same cycle as valid_out=1, the block shall accept the new block and leave blk_count unchanged.
REQ-017 The FSM shall have two states: IDLE (blk_count=0) and SEND (blk_count>0).
  - IDLE->SEND on capture.
  - SEND->IDLE when the last word of the only held block transfers with no simultaneous capture.
REQ-018 ct_word_valid shall equal (state==SEND) and be registered, with no combinational path from valid_out.
REQ-019 Latency: a block captured at edge k with an empty buffer shall present word 0 with ct_word_valid=1 in the cycle after edge k.
REQ-020 A word shall transfer on a rising edge where ct_word_valid=1 and ct_word_ready=1; a 2-bit word index then increments modulo 4.
REQ-021 While ct_word_valid=1 and ct_word_ready=0, ct_word and ct_word_last shall hold stable.
REQ-022 Word order and the ct_word source:
  - MSB_FIRST=1: word index i shall map to head bits [127-32i -: 32].
  - MSB_FIRST=0: word index i shall map to head bits [32i +: 32].
  - ct_word shall be driven from registered buffer storage.
REQ-023 ct_word_last shall be high when index=3 and ct_word_valid=1.
REQ-024 On transfer of the last word, the head entry shall pop.
  - If another block is held, its word 0 shall be presented in the next cycle with no bubble.
REQ-025 When ct_word_valid=0, ct_word shall be 0.
REQ-026 clear_overflow=1 shall clear overflow at the edge; a simultaneous new drop shall take priority, and overflow shall stay 1.
REQ-027 blk_count shall increment on capture, decrement on pop, and remain unchanged when both occur in the same cycle.

Reset
REQ-028 Reset low shall immediately force ct_word_valid=0, ct_word=0, ct_word_last=0, blk_count=0, overflow=0, word index=0 and state IDLE.
REQ-029 Reset asserted mid-block shall discard all buffered and partially sent blocks; no word shall be resent after release.
REQ-030 Buffer data storage need not be reset; only the pointers and count shall be reset.

Structure
REQ-031 Shared package aes_pkg shall hold:
  - AES_BLOCK_W=128, CT_WORD_W=32, WORDS_PER_BLK=4;
  - the FSM state enum {IDLE, SEND}.
REQ-032 The block buffer shall be a sub-module aes_blk_fifo (DEPTH x 128, push/pop/full/empty/count), instantiated once.

Verification
REQ-033 Single block, MSB_FIRST=1: send 128'h69c4e0d86a7b0430d8cdb78070b4c55a with ready held at 1. Expect 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a on 4 consecutive cycles starting 1 cycle after valid_out, and last on the 4th word.
REQ-034 Backpressure: drop ready for 3 cycles during word 1. Expect ct_word to hold 6a7b0430, and no word lost or duplicated.
REQ-035 Back-to-back: 2 blocks on consecutive cycles with ready=1. Expect 8 words in 8 consecutive cycles, with blk_count sequence 1,2,2,2,1,1,1,1,0.
REQ-036 Overflow, DEPTH=2: 3 blocks with ready=0. Expect the 3rd block dropped, overflow=1 and blk_count=2; clear_overflow pulse gives overflow=0.
REQ-037 Full plus pop: with the buffer full, valid_out coincides with the last-word transfer. Expect the block accepted, overflow=0 and blk_count=2.
REQ-038 Reset mid-block: assert reset after word 1. Expect ct_word_valid=0 immediately; after release, with no new input, no words are output.
